// File: rtl/film_scanner_pkg.sv
// Shared types and constants for the film scanner capture path.
package film_scanner_pkg;

  localparam int ADC_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } adc_state_t;

  typedef logic [ADC_DATA_W-1:0] pixel_t;

endpackage

// File: rtl/ccd_adc_reader_sclk_gen.sv
// Serial clock generator for the ADC readout: CLK_DIV-cycle low/high phases,
// rise strobe for data capture and a strobe on the falling edge that ends the word.
module adc_sclk_gen
  import film_scanner_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DATA_W  = ADC_DATA_W
) (
  input  logic                      clk_100M,
  input  logic                      rst,
  input  logic                      run,
  output logic                      adc_sclk,
  output logic                      rise,
  output logic [$clog2(DATA_W)-1:0] bit_cnt,
  output logic                      last_bit
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  logic [DIV_W-1:0] div_cnt_r;
  logic             sclk_r;
  logic [BIT_W-1:0] bit_cnt_r;
  logic             toggle_s;

  // Phase boundary detection and edge strobes
  always_comb begin
    toggle_s = run && (div_cnt_r == DIV_W'(CLK_DIV - 1));
    rise     = toggle_s && !sclk_r;
    last_bit = toggle_s && sclk_r && (bit_cnt_r == BIT_W'(DATA_W - 1));
  end

  // Divider, serial clock and completed-bit counter; idle low whenever not running
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= 1'b0;
      bit_cnt_r <= {BIT_W{1'b0}};
    end else if (!run) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= 1'b0;
      bit_cnt_r <= {BIT_W{1'b0}};
    end else if (toggle_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      sclk_r    <= !sclk_r;
      if (sclk_r) begin
        bit_cnt_r <= last_bit ? {BIT_W{1'b0}} : bit_cnt_r + BIT_W'(1);
      end
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
    end
  end

  assign adc_sclk = sclk_r;
  assign bit_cnt  = bit_cnt_r;

endmodule

// File: rtl/ccd_adc_reader.sv
// CCD video ADC reader: convert on pixel strobe, shift result in MSB-first,
// subtract black level with saturation and emit one pixel with a valid pulse.
module ccd_adc_reader
  import film_scanner_pkg::*;
#(
  parameter int DATA_W      = ADC_DATA_W,
  parameter int CONV_CYCLES = 70,
  parameter int CLK_DIV     = 2
) (
  input  logic              clk_100M,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] dark_level,
  input  logic              overrun_clr,
  output logic              adc_cs,
  output logic              adc_sclk,
  input  logic              adc_sdo,
  output logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] pix_raw,
  output logic              pix_valid,
  output logic              busy,
  output logic              overrun
);

  localparam int CONV_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam int BIT_W  = $clog2(DATA_W);

  adc_state_t        state_r;
  logic [CONV_W-1:0] conv_cnt_r;
  logic [DATA_W-1:0] shreg_r;
  logic [DATA_W-1:0] pix_data_r;
  logic [DATA_W-1:0] pix_raw_r;
  logic [DATA_W-1:0] corr_s;
  logic              cs_r;
  logic              valid_r;
  logic              busy_r;
  logic              overrun_r;
  logic              run_s;
  logic              rise_s;
  logic              last_s;
  logic [BIT_W-1:0]  bit_cnt_s;

  assign run_s = (state_r == SHIFT);

  adc_sclk_gen #(
    .CLK_DIV (CLK_DIV),
    .DATA_W  (DATA_W)
  ) u_sclk_gen (
    .clk_100M (clk_100M),
    .rst      (rst),
    .run      (run_s),
    .adc_sclk (adc_sclk),
    .rise     (rise_s),
    .bit_cnt  (bit_cnt_s),
    .last_bit (last_s)
  );

  // Saturating black-level subtraction
  always_comb begin
    corr_s = {DATA_W{1'b0}};
    if (shreg_r >= dark_level) begin
      corr_s = shreg_r - dark_level;
    end else begin
      corr_s = {DATA_W{1'b0}};
    end
  end

  // Conversion FSM, serial capture, pixel outputs and sticky overrun
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      conv_cnt_r <= {CONV_W{1'b0}};
      shreg_r    <= {DATA_W{1'b0}};
      pix_data_r <= {DATA_W{1'b0}};
      pix_raw_r  <= {DATA_W{1'b0}};
      cs_r       <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      // A rejected start outranks a clear in the same cycle
      if (start && busy_r) begin
        overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        overrun_r <= 1'b0;
      end
      // First capture of a word discards whatever the register held before
      if (rise_s) begin
        shreg_r <= (bit_cnt_s == {BIT_W{1'b0}}) ? {{(DATA_W-1){1'b0}}, adc_sdo}
                                                : {shreg_r[DATA_W-2:0], adc_sdo};
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= CONV;
            conv_cnt_r <= {CONV_W{1'b0}};
            cs_r       <= 1'b1;
            busy_r     <= 1'b1;
          end
        end
        CONV: begin
          if (conv_cnt_r == CONV_W'(CONV_CYCLES - 1)) begin
            state_r <= SHIFT;
            cs_r    <= 1'b0;
          end else begin
            conv_cnt_r <= conv_cnt_r + CONV_W'(1);
          end
        end
        SHIFT: begin
          if (last_s) begin
            state_r    <= DONE;
            pix_raw_r  <= shreg_r;
            pix_data_r <= corr_s;
            valid_r    <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          cs_r    <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign adc_cs    = cs_r;
  assign pix_data  = pix_data_r;
  assign pix_raw   = pix_raw_r;
  assign pix_valid = valid_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_ccd_adc_reader.sv
// Directed bench for ccd_adc_reader: default build plus a 12-bit fast build.
module tb_ccd_adc_reader;

  logic        clk_100M = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dark_level;
  logic        overrun_clr;
  logic        adc_cs, adc_sclk;
  logic        adc_sdo = 1'b0;
  logic [15:0] pix_data, pix_raw;
  logic        pix_valid, busy, overrun;

  logic        start2;
  logic [11:0] dark2;
  logic        overrun_clr2;
  logic        adc_cs2, adc_sclk2;
  logic        adc_sdo2 = 1'b0;
  logic [11:0] pix_data2, pix_raw2;
  logic        pix_valid2, busy2, overrun2;

  int checks = 0;
  int errors = 0;

  always #5 clk_100M = ~clk_100M;

  ccd_adc_reader dut (
    .clk_100M(clk_100M), .rst(rst), .start(start), .dark_level(dark_level),
    .overrun_clr(overrun_clr), .adc_cs(adc_cs), .adc_sclk(adc_sclk), .adc_sdo(adc_sdo),
    .pix_data(pix_data), .pix_raw(pix_raw), .pix_valid(pix_valid), .busy(busy),
    .overrun(overrun)
  );

  ccd_adc_reader #(.DATA_W(12), .CONV_CYCLES(1), .CLK_DIV(1)) dut2 (
    .clk_100M(clk_100M), .rst(rst), .start(start2), .dark_level(dark2),
    .overrun_clr(overrun_clr2), .adc_cs(adc_cs2), .adc_sclk(adc_sclk2), .adc_sdo(adc_sdo2),
    .pix_data(pix_data2), .pix_raw(pix_raw2), .pix_valid(pix_valid2), .busy(busy2),
    .overrun(overrun2)
  );

  // ADC models: MSB presented when cs falls, next bit on each sclk falling edge
  logic [15:0] adc_word = 16'h0000;
  int          bit_idx = 0;
  logic        cs_d = 1'b0, sclk_d = 1'b0;
  always @(adc_cs or adc_sclk) begin
    if (cs_d && !adc_cs) begin
      bit_idx = 15;
      adc_sdo = adc_word[bit_idx];
    end else if (sclk_d && !adc_sclk && bit_idx > 0) begin
      bit_idx = bit_idx - 1;
      adc_sdo = adc_word[bit_idx];
    end
    cs_d   = adc_cs;
    sclk_d = adc_sclk;
  end

  logic [11:0] adc_word2 = 12'h000;
  int          bit_idx2 = 0;
  logic        cs2_d = 1'b0, sclk2_d = 1'b0;
  always @(adc_cs2 or adc_sclk2) begin
    if (cs2_d && !adc_cs2) begin
      bit_idx2 = 11;
      adc_sdo2 = adc_word2[bit_idx2];
    end else if (sclk2_d && !adc_sclk2 && bit_idx2 > 0) begin
      bit_idx2 = bit_idx2 - 1;
      adc_sdo2 = adc_word2[bit_idx2];
    end
    cs2_d   = adc_cs2;
    sclk2_d = adc_sclk2;
  end

  task automatic test_reset;
    @(negedge clk_100M);
    checks++; if (adc_cs !== 1'b0)      begin errors++; $display("FAIL reset_cs: got %b expected 0", adc_cs); end
    checks++; if (adc_sclk !== 1'b0)    begin errors++; $display("FAIL reset_sclk: got %b expected 0", adc_sclk); end
    checks++; if (pix_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid: got %b expected 0", pix_valid); end
    checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL reset_pix_data: got %h expected 0000", pix_data); end
    checks++; if (pix_raw !== 16'h0000)  begin errors++; $display("FAIL reset_pix_raw: got %h expected 0000", pix_raw); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    int cs_cnt = 0, cs_first = 0, cs_last = 0, rises = 0, first_rise = 0, prev_rise = 0;
    int bad_gap = 0, val_cnt = 0, val_cyc = 0;
    logic sclk_prev = 1'b0;
    logic busy135 = 1'b0, busy136 = 1'b1;
    logic [15:0] vd = 16'h0000, vr = 16'h0000;
    adc_word = 16'hA5C3; dark_level = 16'h0000;
    @(negedge clk_100M); start = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      @(negedge clk_100M);
      start = 1'b0;
      if (adc_cs) begin cs_cnt++; if (cs_first == 0) cs_first = c; cs_last = c; end
      if (adc_sclk && !sclk_prev) begin
        rises++;
        if (first_rise == 0) first_rise = c;
        else if (c - prev_rise != 4) bad_gap++;
        prev_rise = c;
      end
      sclk_prev = adc_sclk;
      if (pix_valid) begin val_cnt++; val_cyc = c; vd = pix_data; vr = pix_raw; end
      if (c == 135) busy135 = busy;
      if (c == 136) busy136 = busy;
    end
    checks++; if (cs_cnt != 70)     begin errors++; $display("FAIL single_cs_len: got %0d expected 70", cs_cnt); end
    checks++; if (cs_first != 1)    begin errors++; $display("FAIL single_cs_first: got %0d expected 1", cs_first); end
    checks++; if (cs_last != 70)    begin errors++; $display("FAIL single_cs_last: got %0d expected 70", cs_last); end
    checks++; if (rises != 16)      begin errors++; $display("FAIL single_sclk_rises: got %0d expected 16", rises); end
    checks++; if (first_rise != 73) begin errors++; $display("FAIL single_first_rise: got %0d expected 73", first_rise); end
    checks++; if (bad_gap != 0)     begin errors++; $display("FAIL single_sclk_period: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (val_cnt != 1)     begin errors++; $display("FAIL single_valid_count: got %0d expected 1", val_cnt); end
    checks++; if (val_cyc != 135)   begin errors++; $display("FAIL single_valid_cycle: got %0d expected 135", val_cyc); end
    checks++; if (vr !== 16'hA5C3)  begin errors++; $display("FAIL single_raw: got %h expected a5c3", vr); end
    checks++; if (vd !== 16'hA5C3)  begin errors++; $display("FAIL single_data: got %h expected a5c3", vd); end
    checks++; if (busy135 !== 1'b1) begin errors++; $display("FAIL single_busy135: got %b expected 1", busy135); end
    checks++; if (busy136 !== 1'b0) begin errors++; $display("FAIL single_busy136: got %b expected 0", busy136); end
  endtask

  task automatic do_conv(input logic [15:0] word, input logic [15:0] dark,
                         input logic [15:0] exp_data, input string name);
    int val_cnt = 0, val_cyc = 0;
    logic [15:0] vd = 16'h0000, vr = 16'h0000;
    adc_word = word; dark_level = dark;
    @(negedge clk_100M); start = 1'b1;
    for (int c = 1; c <= 137; c++) begin
      @(negedge clk_100M);
      start = 1'b0;
      if (pix_valid) begin val_cnt++; val_cyc = c; vd = pix_data; vr = pix_raw; end
    end
    checks++; if (val_cnt != 1 || val_cyc != 135) begin errors++; $display("FAIL %s_valid: got %0d at %0d expected 1 at 135", name, val_cnt, val_cyc); end
    checks++; if (vr !== word)       begin errors++; $display("FAIL %s_raw: got %h expected %h", name, vr, word); end
    checks++; if (vd !== exp_data)   begin errors++; $display("FAIL %s_data: got %h expected %h", name, vd, exp_data); end
    checks++; if (pix_data !== exp_data) begin errors++; $display("FAIL %s_hold: got %h expected %h", name, pix_data, exp_data); end
  endtask

  task automatic test_dark;
    do_conv(16'h1234, 16'h0234, 16'h1000, "dark_sub");
    do_conv(16'h0080, 16'h0100, 16'h0000, "dark_sat");
    do_conv(16'hFFFF, 16'h0000, 16'hFFFF, "dark_full");
  endtask

  task automatic test_back_to_back;
    int val_cnt = 0, c1 = 0, c2 = 0, ov_seen = 0;
    logic [15:0] d1 = 16'h0000, d2 = 16'h0000;
    adc_word = 16'h0001; dark_level = 16'h0000;
    @(negedge clk_100M); start = 1'b1;
    for (int c = 1; c <= 275; c++) begin
      @(negedge clk_100M);
      start = (c == 136);
      if (c == 136) adc_word = 16'h8000;
      if (overrun) ov_seen++;
      if (pix_valid) begin
        val_cnt++;
        if (val_cnt == 1) begin c1 = c; d1 = pix_data; end
        else begin c2 = c; d2 = pix_data; end
      end
    end
    checks++; if (val_cnt != 2)     begin errors++; $display("FAIL b2b_count: got %0d expected 2", val_cnt); end
    checks++; if (c1 != 135)        begin errors++; $display("FAIL b2b_first_cycle: got %0d expected 135", c1); end
    checks++; if (c2 != 271)        begin errors++; $display("FAIL b2b_second_cycle: got %0d expected 271", c2); end
    checks++; if (d1 !== 16'h0001)  begin errors++; $display("FAIL b2b_first_data: got %h expected 0001", d1); end
    checks++; if (d2 !== 16'h8000)  begin errors++; $display("FAIL b2b_second_data: got %h expected 8000", d2); end
    checks++; if (ov_seen != 0)     begin errors++; $display("FAIL b2b_overrun: got %0d cycles expected 0", ov_seen); end
  endtask

  task automatic test_overrun;
    int val_cnt = 0, val_cyc = 0;
    logic ov50 = 1'b1, ov51 = 1'b0, ov61 = 1'b0, ov71 = 1'b1;
    logic [15:0] vd = 16'h0000, vr = 16'h0000;
    adc_word = 16'h5AA5; dark_level = 16'h00A5;
    @(negedge clk_100M); start = 1'b1;
    for (int c = 1; c <= 137; c++) begin
      @(negedge clk_100M);
      if (c == 50) ov50 = overrun;
      if (c == 51) ov51 = overrun;
      if (c == 61) ov61 = overrun;
      if (c == 71) ov71 = overrun;
      if (pix_valid) begin val_cnt++; val_cyc = c; vd = pix_data; vr = pix_raw; end
      start       = (c == 50) || (c == 60);
      overrun_clr = (c == 60) || (c == 70);
    end
    checks++; if (ov50 !== 1'b0)   begin errors++; $display("FAIL ovr_before: got %b expected 0", ov50); end
    checks++; if (ov51 !== 1'b1)   begin errors++; $display("FAIL ovr_set: got %b expected 1", ov51); end
    checks++; if (ov61 !== 1'b1)   begin errors++; $display("FAIL ovr_set_wins: got %b expected 1", ov61); end
    checks++; if (ov71 !== 1'b0)   begin errors++; $display("FAIL ovr_clear: got %b expected 0", ov71); end
    checks++; if (val_cnt != 1 || val_cyc != 135) begin errors++; $display("FAIL ovr_valid: got %0d at %0d expected 1 at 135", val_cnt, val_cyc); end
    checks++; if (vr !== 16'h5AA5) begin errors++; $display("FAIL ovr_raw: got %h expected 5aa5", vr); end
    checks++; if (vd !== 16'h5A00) begin errors++; $display("FAIL ovr_data: got %h expected 5a00", vd); end
  endtask

  task automatic test_reset_mid_shift;
    int saw_valid = 0;
    logic sclk_pre = 1'b0;
    adc_word = 16'h3C5A; dark_level = 16'h0000;
    @(negedge clk_100M); start = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      @(negedge clk_100M);
      start = 1'b0;
      if (pix_valid) saw_valid++;
    end
    sclk_pre = adc_sclk;
    #1 rst = 1'b1;
    #1;
    checks++; if (sclk_pre !== 1'b1) begin errors++; $display("FAIL rst_sclk_before: got %b expected 1", sclk_pre); end
    checks++; if (adc_cs !== 1'b0)   begin errors++; $display("FAIL rst_cs_now: got %b expected 0", adc_cs); end
    checks++; if (adc_sclk !== 1'b0) begin errors++; $display("FAIL rst_sclk_now: got %b expected 0", adc_sclk); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy_now: got %b expected 0", busy); end
    repeat (3) @(negedge clk_100M);
    rst = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk_100M);
      if (pix_valid) saw_valid++;
    end
    checks++; if (saw_valid != 0)     begin errors++; $display("FAIL rst_no_valid: got %0d expected 0", saw_valid); end
    checks++; if (pix_raw !== 16'h0000) begin errors++; $display("FAIL rst_raw_cleared: got %h expected 0000", pix_raw); end
    do_conv(16'h3C5A, 16'h005A, 16'h3C00, "post_reset");
  endtask

  task automatic test_param_sweep;
    int cs_cnt = 0, rises = 0, first_rise = 0, val_cnt = 0, val_cyc = 0;
    logic sclk_prev = 1'b0;
    logic [11:0] vd = 12'h000, vr = 12'h000;
    adc_word2 = 12'hB6D; dark2 = 12'h100;
    @(negedge clk_100M); start2 = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk_100M);
      start2 = 1'b0;
      if (adc_cs2) cs_cnt++;
      if (adc_sclk2 && !sclk_prev) begin rises++; if (first_rise == 0) first_rise = c; end
      sclk_prev = adc_sclk2;
      if (pix_valid2) begin val_cnt++; val_cyc = c; vd = pix_data2; vr = pix_raw2; end
    end
    checks++; if (cs_cnt != 1)      begin errors++; $display("FAIL sweep_cs_len: got %0d expected 1", cs_cnt); end
    checks++; if (rises != 12)      begin errors++; $display("FAIL sweep_rises: got %0d expected 12", rises); end
    checks++; if (first_rise != 3)  begin errors++; $display("FAIL sweep_first_rise: got %0d expected 3", first_rise); end
    checks++; if (val_cnt != 1 || val_cyc != 26) begin errors++; $display("FAIL sweep_valid: got %0d at %0d expected 1 at 26", val_cnt, val_cyc); end
    checks++; if (vr !== 12'hB6D)   begin errors++; $display("FAIL sweep_raw: got %h expected b6d", vr); end
    checks++; if (vd !== 12'hA6D)   begin errors++; $display("FAIL sweep_data: got %h expected a6d", vd); end
    checks++; if (busy2 !== 1'b0 || overrun2 !== 1'b0) begin errors++; $display("FAIL sweep_idle: got busy %b overrun %b expected 0 0", busy2, overrun2); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dark_level = 16'h0000; overrun_clr = 1'b0;
    start2 = 1'b0; dark2 = 12'h000; overrun_clr2 = 1'b0;
    repeat (3) @(negedge clk_100M);
    test_reset();
    test_single();
    test_dark();
    test_back_to_back();
    test_overrun();
    test_reset_mid_shift();
    test_param_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
